asrm_exec_ctrl: RTL and testbench
=================================

ASRM_EXEC_CTRL -- requirements
Module: asrm_exec_ctrl

Interface
REQ-001 Parameter: wordsize, default 16, width of every register and data port.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instr_valid  input  1  instruction byte on `instruction` is offered.
REQ-005 instruction  input  8  offered instruction: [7:4] opcode, [3:0] register index/immediate.
REQ-006 instr_ready  output  1  block can accept an instruction this cycle.
REQ-007 alu_instruction  output  8  latched instruction presented to the ALU.
REQ-008 working_register  output  wordsize  current R0 (WR) contents.
REQ-009 other_register  output  wordsize  contents of R[alu_instruction[3:0]].
REQ-010 status_register  output  wordsize  current R1 (SR) contents.
REQ-011 alu_out  input  wordsize  ALU result for alu_instruction.
REQ-012 alu_out_reg  input  4  destination register index of alu_out.
REQ-013 done  output  1  one-cycle pulse: previous instruction fully written back.
REQ-014 dbg_sel  input  4  debug register select.
REQ-015 dbg_data  output  wordsize  combinational R[dbg_sel].

Function
REQ-016 Block SHALL hold a bank of 16 registers R0..R15, each wordsize bits; R0 = WR, R1 = SR.
REQ-017 FSM SHALL have states IDLE, EXEC, DONE; IDLE->EXEC on instr_valid&&instr_ready; EXEC->DONE unconditionally; DONE->IDLE unconditionally.
REQ-018 instr_ready SHALL be 1 only in IDLE; instr_valid in EXEC/DONE SHALL be ignored, no state change.
REQ-019 On handshake edge, instruction SHALL be latched into alu_instruction and held unchanged until the next handshake.
REQ-020 other_register/working_register/status_register/dbg_data SHALL be combinational reads of the bank (pre-write values during EXEC).
REQ-021 At EXEC->DONE edge exactly one register write SHALL occur, selected by alu_instruction[7:4]:
- 0x1 SET: R0 <= zero-extended alu_instruction[3:0].
- 0x2 READ: R0 <= R[x], x = alu_instruction[3:0]; READ R0 leaves R0 unchanged.
- 0x3 CPY: R[x] <= R0; CPY R0 is a no-op write.
- any other opcode: R[alu_out_reg] <= alu_out (any index 0..15 accepted).
REQ-022 Opcodes 0x1-0x3 SHALL NOT use alu_out/alu_out_reg.
REQ-023 done SHALL be 1 exactly in DONE state; latency handshake edge -> written value visible = 1 edge after EXEC, i.e. 2 edges; throughput 1 instruction per 3 cycles.
REQ-024 dbg_sel equal to the register being written SHALL show old value during EXEC, new value from DONE onward.
REQ-025 No arithmetic is performed in this block; widths SHALL be passed through unmodified.

Reset
REQ-026 reset high at a rising edge SHALL force state IDLE, all R0..R15 = 0, alu_instruction = 0, done = 0, instr_ready = 1 next cycle.
REQ-027 reset SHALL take priority over any handshake or write-back in the same edge; a reset during EXEC SHALL discard the pending write.
REQ-028 Outputs after reset: working_register = status_register = other_register = dbg_data = 0.

Verification
REQ-029 Reset, then SET 0x1A (instruction 0x1A, valid 1 cycle) -> done pulse 2 edges after handshake, WR = 0x000A, instr_ready low for exactly 2 cycles.
REQ-030 SET 0x5, CPY R7 (0x37), SET 0x3, READ R7 (0x27) -> dbg_sel=7 shows 0x0005, WR ends 0x0005.
REQ-031 ALU op with alu_out = 0xBEEF, alu_out_reg = 1 -> SR = 0xBEEF after DONE; R0 unchanged; status_register follows.
REQ-032 Hold instr_valid high continuously with a stream of SET values 1,2,3 -> exactly one accept per 3 cycles, done pulses 3 cycles apart, final WR = 0x0003.
REQ-033 Assert reset during EXEC of SET 0xF -> WR remains 0x0000, no done pulse, instr_ready = 1 the cycle after reset release.
REQ-034 ALU op with alu_out_reg = 15, dbg_sel = 15 -> dbg_data old value in EXEC, alu_out value in DONE.

Source files
------------

// File: rtl/asrm_exec_ctrl_if.sv
// Instruction handshake, ALU write-back and register read-out bundle for asrm_exec_ctrl.
// The master (instruction source / ALU) drives requests; the slave is the controller.
interface asrm_exec_ctrl_if #(
   parameter int wordsize = 16
);
   logic                instr_valid;
   logic [7:0]          instruction;
   logic                instr_ready;
   logic [7:0]          alu_instruction;
   logic [wordsize-1:0] working_register;
   logic [wordsize-1:0] other_register;
   logic [wordsize-1:0] status_register;
   logic [wordsize-1:0] alu_out;
   logic [3:0]          alu_out_reg;
   logic                done;
   logic [3:0]          dbg_sel;
   logic [wordsize-1:0] dbg_data;

   modport master (
      output instr_valid, instruction, alu_out, alu_out_reg, dbg_sel,
      input  instr_ready, alu_instruction, working_register, other_register,
             status_register, done, dbg_data
   );

   modport slave (
      input  instr_valid, instruction, alu_out, alu_out_reg, dbg_sel,
      output instr_ready, alu_instruction, working_register, other_register,
             status_register, done, dbg_data
   );
endinterface

// File: rtl/asrm_exec_ctrl.sv
// Three-phase execution controller: accept an instruction, present it to the ALU,
// then write exactly one register of a 16-entry bank (R0 = WR, R1 = SR).
module asrm_exec_ctrl #(
   parameter int wordsize = 16
) (
   input  logic            clk,
   input  logic            reset,
   asrm_exec_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_reg, state_next;
   logic [7:0]          alu_instruction_reg;
   logic [wordsize-1:0] bank_reg [16];
   logic                handshake;
   logic                write_en;
   logic [3:0]          write_idx;
   logic [wordsize-1:0] write_data;
   logic [15:0]         write_sel;
   logic [3:0]          operand;

   assign operand = alu_instruction_reg[3:0];

   always_comb begin
      state_next = state_reg;
      handshake  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.instr_valid) begin
               handshake  = 1'b1;
               state_next = EXEC;
            end
         end
         EXEC:    state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign write_en = (state_reg == EXEC);

   // Local opcodes never look at the ALU result; everything else is a plain ALU write-back.
   always_comb begin
      write_idx  = 4'd0;
      write_data = bank_reg[0];
      case (alu_instruction_reg[7:4])
         4'h1: write_data = wordsize'(operand);
         4'h2: write_data = bank_reg[operand];
         4'h3: begin
            write_idx  = operand;
            write_data = bank_reg[0];
         end
         default: begin
            write_idx  = bus.alu_out_reg;
            write_data = bus.alu_out;
         end
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_write_sel
         assign write_sel[gi] = write_en && (write_idx == 4'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg           <= IDLE;
         alu_instruction_reg <= 8'd0;
         for (int i = 0; i < 16; i++) begin
            bank_reg[i] <= '0;
         end
      end else begin
         state_reg <= state_next;
         if (handshake) begin
            alu_instruction_reg <= bus.instruction;
         end
         for (int i = 0; i < 16; i++) begin
            if (write_sel[i]) begin
               bank_reg[i] <= write_data;
            end
         end
      end
   end

   assign bus.instr_ready      = (state_reg == IDLE);
   assign bus.done             = (state_reg == DONE);
   assign bus.alu_instruction  = alu_instruction_reg;
   assign bus.working_register = bank_reg[0];
   assign bus.status_register  = bank_reg[1];
   assign bus.other_register   = bank_reg[operand];
   assign bus.dbg_data         = bank_reg[bus.dbg_sel];
endmodule

// File: tb/tb_asrm_exec_ctrl.sv
// Self-checking bench for asrm_exec_ctrl: directed vector table, streaming and reset
// corner cases, then random instructions against a register-array model.
module tb_asrm_exec_ctrl;
   localparam int W = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   asrm_exec_ctrl_if #(.wordsize(W)) bus ();
   asrm_exec_ctrl #(.wordsize(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_vec = 0;
   int n_err = 0;
   logic [W-1:0] m_regs [16];

   typedef struct {
      logic [7:0]   ins;
      logic [W-1:0] ao;
      logic [3:0]   aor;
      logic [3:0]   dsel;
      logic [W-1:0] wr;
      logic [W-1:0] sr;
      logic [W-1:0] dbg;
      logic [W-1:0] oth;
   } vec_t;
   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void model_exec(input logic [7:0] ins, input logic [W-1:0] ao,
                                      input logic [3:0] aor);
      logic [3:0] x;
      x = ins[3:0];
      case (ins[7:4])
         4'h1:    m_regs[0] = W'(x);
         4'h2:    m_regs[0] = m_regs[x];
         4'h3:    m_regs[x] = m_regs[0];
         default: m_regs[aor] = ao;
      endcase
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
   endfunction

   // One full instruction: handshake, EXEC, DONE, back to IDLE.
   task automatic do_instr(input logic [7:0] ins, input logic [W-1:0] ao,
                           input logic [3:0] aor, input logic [3:0] dsel);
      @(negedge clk);
      check("pre_ready", bus.instr_ready, 1);
      bus.instr_valid = 1'b1;
      bus.instruction = ins;
      bus.alu_out     = ao;
      bus.alu_out_reg = aor;
      bus.dbg_sel     = dsel;
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      check("exec_ready", bus.instr_ready, 0);
      check("exec_done", bus.done, 0);
      check("alu_instruction", bus.alu_instruction, ins);
      check("dbg_exec_old", bus.dbg_data, m_regs[dsel]);
      model_exec(ins, ao, aor);
      @(posedge clk); #1;
      check("done_pulse", bus.done, 1);
      check("done_ready", bus.instr_ready, 0);
      check("dbg_done_new", bus.dbg_data, m_regs[dsel]);
      @(posedge clk); #1;
      check("idle_done", bus.done, 0);
      check("idle_ready", bus.instr_ready, 1);
   endtask

   initial begin
      vecs[0]  = '{8'h1A, 16'hFFFF, 4'd1, 4'd0, 16'h000A, 16'h0000, 16'h000A, 16'h0000};
      vecs[1]  = '{8'h15, 16'hFFFF, 4'd1, 4'd0, 16'h0005, 16'h0000, 16'h0005, 16'h0000};
      vecs[2]  = '{8'h37, 16'hFFFF, 4'd1, 4'd7, 16'h0005, 16'h0000, 16'h0005, 16'h0005};
      vecs[3]  = '{8'h13, 16'hFFFF, 4'd1, 4'd7, 16'h0003, 16'h0000, 16'h0005, 16'h0000};
      vecs[4]  = '{8'h27, 16'hFFFF, 4'd1, 4'd7, 16'h0005, 16'h0000, 16'h0005, 16'h0005};
      vecs[5]  = '{8'h40, 16'hBEEF, 4'd1, 4'd1, 16'h0005, 16'hBEEF, 16'hBEEF, 16'h0005};
      vecs[6]  = '{8'h91, 16'h1234, 4'hF, 4'hF, 16'h0005, 16'hBEEF, 16'h1234, 16'hBEEF};
      vecs[7]  = '{8'h21, 16'hFFFF, 4'd3, 4'd0, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
      vecs[8]  = '{8'h30, 16'hFFFF, 4'd3, 4'd0, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
      vecs[9]  = '{8'h3F, 16'hFFFF, 4'd3, 4'hF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
      vecs[10] = '{8'h00, 16'h0042, 4'd0, 4'd0, 16'h0042, 16'hBEEF, 16'h0042, 16'h0042};
      vecs[11] = '{8'hF2, 16'hA5A5, 4'd2, 4'd2, 16'h0042, 16'hBEEF, 16'hA5A5, 16'hA5A5};

      reset           = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instruction = 8'h00;
      bus.alu_out     = '0;
      bus.alu_out_reg = 4'd0;
      bus.dbg_sel     = 4'd0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_ready", bus.instr_ready, 1);
      check("rst_done", bus.done, 0);
      check("rst_wr", bus.working_register, 0);
      check("rst_sr", bus.status_register, 0);
      check("rst_other", bus.other_register, 0);
      check("rst_dbg", bus.dbg_data, 0);
      check("rst_alu_instr", bus.alu_instruction, 0);

      for (int v = 0; v < 12; v++) begin
         do_instr(vecs[v].ins, vecs[v].ao, vecs[v].aor, vecs[v].dsel);
         check("vec_wr", bus.working_register, vecs[v].wr);
         check("vec_sr", bus.status_register, vecs[v].sr);
         check("vec_dbg", bus.dbg_data, vecs[v].dbg);
         check("vec_other", bus.other_register, vecs[v].oth);
         $display("vec %0d: instr=0x%02h wr=0x%04h sr=0x%04h dbg=0x%04h", v, vecs[v].ins,
                  bus.working_register, bus.status_register, bus.dbg_data);
      end

      // Valid held high across a stream; junk offered while busy must be ignored.
      begin
         int k;
         int acc[$];
         int dn[$];
         logic [7:0] vals [3];
         vals[0] = 8'h11; vals[1] = 8'h12; vals[2] = 8'h13;
         k = 0;
         bus.dbg_sel = 4'd0;
         for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (bus.done) dn.push_back(cyc);
            if (bus.instr_ready) begin
               if (k < 3) begin
                  bus.instr_valid = 1'b1;
                  bus.instruction = vals[k];
                  acc.push_back(cyc);
                  model_exec(vals[k], '0, 4'd0);
                  k++;
               end else begin
                  bus.instr_valid = 1'b0;
               end
            end else begin
               bus.instruction = 8'h1F;
            end
         end
         bus.instr_valid = 1'b0;
         check("stream_accepts", acc.size(), 3);
         check("stream_dones", dn.size(), 3);
         for (int i = 0; i < 3; i++) begin
            check("stream_accept_cyc", (i < acc.size()) ? acc[i] : -1, 3 * i);
            check("stream_done_cyc", (i < dn.size()) ? dn[i] : -1, 3 * i + 2);
         end
         check("stream_wr", bus.working_register, 16'h0003);
         check("stream_alu_instr", bus.alu_instruction, 8'h13);
         $display("stream: accepts=%0d dones=%0d wr=0x%04h", acc.size(), dn.size(),
                  bus.working_register);
      end

      for (int r = 0; r < 40; r++) begin
         logic [7:0]   ins;
         logic [W-1:0] ao;
         logic [3:0]   aor;
         logic [3:0]   dsel;
         ins  = 8'($urandom);
         ao   = W'($urandom);
         aor  = 4'($urandom_range(0, 15));
         dsel = 4'($urandom_range(0, 15));
         do_instr(ins, ao, aor, dsel);
         check("rnd_wr", bus.working_register, m_regs[0]);
         check("rnd_sr", bus.status_register, m_regs[1]);
         check("rnd_other", bus.other_register, m_regs[ins[3:0]]);
         check("rnd_dbg", bus.dbg_data, m_regs[dsel]);
         $display("rnd %0d: instr=0x%02h ao=0x%04h aor=%0d wr=0x%04h sr=0x%04h", r, ins, ao,
                  aor, bus.working_register, bus.status_register);
      end

      // Reset landing on the EXEC->DONE edge must drop the pending write.
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.instruction = 8'h1F;
      bus.dbg_sel     = 4'd0;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      check("rexec_busy", bus.instr_ready, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      check("rexec_wr", bus.working_register, 0);
      check("rexec_done", bus.done, 0);
      check("rexec_ready", bus.instr_ready, 1);
      check("rexec_alu_instr", bus.alu_instruction, 0);
      @(posedge clk); #1;
      check("rexec_done_after", bus.done, 0);
      check("rexec_wr_after", bus.working_register, 0);
      check("rexec_ready_after", bus.instr_ready, 1);
      for (int i = 0; i < 16; i++) begin
         bus.dbg_sel = 4'(i);
         #1;
         check("rexec_bank_zero", bus.dbg_data, m_regs[i]);
      end
      $display("reset-in-exec: wr=0x%04h ready=%0d", bus.working_register, bus.instr_ready);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
